mdu_issue_ctrl: RTL and testbench
=================================

Name: mdu_issue_ctrl

Overview:
- Requester side of the MDU operation interface; sits in the EX stage between the ID/EX pipeline register and a multi-cycle MDU.
- Accepts one decoded mul/div/rem operation at a time and registers its operands.
- Resolves RISC-V M-extension corner cases locally: divide by zero and signed overflow.
- Otherwise issues a req/gnt request to the MDU, waits for rvalid, and holds the result for writeback until it is accepted; handles pipeline flush.

Parameters:
- WORD_SIZE, 32, operand/result width.
- MDU_OP_W, 3, operator width (from mdu_pkg).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- ex_valid_i  in  1  EX holds a valid instruction.
- mdu_en_i  in  1  instruction is an MDU op.
- ex_ready_o  out  1  block can accept an op.
- operator_i  in  MDU_OP_W  MDU operator.
- operand_a_i  in  WORD_SIZE  rs1 value.
- operand_b_i  in  WORD_SIZE  rs2 value.
- rd_addr_i  in  5  destination register.
- flush_i  in  1  kill the in-flight op.
- mdu_req_o  out  1  request to MDU.
- mdu_gnt_i  in  1  MDU accepted the request.
- mdu_operator_o  out  MDU_OP_W  registered operator.
- mdu_operand_a_o  out  WORD_SIZE  registered operand a.
- mdu_operand_b_o  out  WORD_SIZE  registered operand b.
- mdu_rvalid_i  in  1  MDU result valid (one-cycle pulse).
- mdu_result_i  in  WORD_SIZE  MDU result.
- wb_valid_o  out  1  result available for writeback.
- wb_ready_i  in  1  writeback accepts the result.
- wb_rd_addr_o  out  5  destination of the result.
- wb_data_o  out  WORD_SIZE  result data.
- busy_o  out  1  state is not IDLE.

Behaviour:
- All state updates on posedge clk; rst_n low at an edge forces IDLE.
- Reset values: kill=0, ex_ready_o=1, every other output 0, all registers 0.
- Reset mid-operation abandons the op with no writeback; the MDU shares rst_n, so no stale response can arrive.
- ex_ready_o = (state==IDLE).
- Accept condition: ex_valid_i & mdu_en_i & ex_ready_o & !flush_i. On accept, register operator, operands and rd.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE, accept with a special case: go to DONE next cycle with the precomputed result; no MDU request issued (latency 1).
- IDLE, accept otherwise: go to REQ.
- Special case, divide by zero (operand_b==0):
  - DIV and DIVU give all ones.
  - REM and REMU give operand_a.
- Special case, signed overflow (DIV/REM, a==0x80000000, b==0xFFFFFFFF):
  - DIV gives 0x80000000.
  - REM gives 0.
- REQ:
  - mdu_req_o=1; operator and operands stay stable until mdu_gnt_i.
  - On gnt go to WAIT.
  - If mdu_rvalid_i arrives in the same cycle as gnt, treat it as WAIT+rvalid.
- WAIT: on mdu_rvalid_i, capture mdu_result_i and go to DONE, or to IDLE if kill=1.
- DONE:
  - wb_valid_o=1; wb_data_o and wb_rd_addr_o are stable while wb_ready_i is low.
  - On wb_ready_i go to IDLE.
- Flush:
  - In IDLE, flush_i blocks accept.
  - In REQ or WAIT, set kill; the request is never withdrawn; the response is drained and dropped, then the FSM returns to IDLE and kill clears.
  - In DONE, go to IDLE immediately; wb_valid_o drops next cycle.
  - flush_i and wb_ready_i together in DONE also go to IDLE; writeback consumes the data that cycle.
- mdu_rvalid_i outside REQ/WAIT is ignored.
- Only one operation is ever outstanding.

Decomposition:
- mdu_pkg holds:
  - MDU_OP_W.
  - typedef enum mdu_op_e in funct3 order: MDU_MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7.
  - FSM state typedef.
- One combinational sub-module, mdu_special_case: inputs operator and operands; outputs hit flag and result.

Test Plan:
- MUL a=3 b=5; gnt 2 cycles after req; rvalid 4 cycles after gnt -> mdu_req_o held 3 cycles with stable operands; wb_valid_o with wb_data_o=15, rd echoed.
- DIVU a=7 b=0 -> no mdu_req_o; wb_valid_o one cycle after accept, data 0xFFFFFFFF. REM a=7 b=0 -> data 7.
- DIV a=0x80000000 b=0xFFFFFFFF -> 0x80000000, no request. REM with the same operands -> 0.
- DIV issued, flush_i pulsed in WAIT, rvalid 3 cycles later -> wb_valid_o never asserts; ex_ready_o returns 1 the cycle after rvalid.
- Result in DONE, wb_ready_i low 3 cycles -> wb_valid_o and wb_data_o stable, ex_ready_o=0; on ready, back to IDLE and a back-to-back op is accepted.
- rst_n low during WAIT -> next cycle IDLE, all outputs at reset values, ex_ready_o=1.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared types for the MDU issue path: operator encoding (funct3 order) and
// the issue-controller FSM states.
package mdu_pkg;

  localparam int MDU_OP_W = 3;

  typedef enum logic [MDU_OP_W-1:0] {
    MDU_MUL    = 3'd0,
    MDU_MULH   = 3'd1,
    MDU_MULHSU = 3'd2,
    MDU_MULHU  = 3'd3,
    MDU_DIV    = 3'd4,
    MDU_DIVU   = 3'd5,
    MDU_REM    = 3'd6,
    MDU_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } mdu_state_e;

endpackage

// File: rtl/mdu_special_case.sv
// Combinational detection of the RISC-V M-extension divide corner cases
// (divide by zero, signed overflow) together with their architected results.
module mdu_special_case
  import mdu_pkg::*;
#(
  parameter int WORD_SIZE = 32
) (
  input  logic [MDU_OP_W-1:0]         operator_i,
  input  logic signed [WORD_SIZE-1:0] operand_a_i,
  input  logic signed [WORD_SIZE-1:0] operand_b_i,
  output logic                        hit_o,
  output logic signed [WORD_SIZE-1:0] result_o
);

  localparam logic signed [WORD_SIZE-1:0] INT_MIN = {1'b1, {(WORD_SIZE-1){1'b0}}};
  localparam logic signed [WORD_SIZE-1:0] MINUS_ONE = '1;

  mdu_op_e op;
  logic    is_div;
  logic    is_signed_div;
  logic    is_rem;
  logic    div_zero;
  logic    div_ovf;

  assign op            = mdu_op_e'(operator_i);
  assign is_div        = (op == MDU_DIV) || (op == MDU_DIVU) || (op == MDU_REM) || (op == MDU_REMU);
  assign is_signed_div = (op == MDU_DIV) || (op == MDU_REM);
  assign is_rem        = (op == MDU_REM) || (op == MDU_REMU);
  assign div_zero      = is_div && (operand_b_i == '0);
  assign div_ovf       = is_signed_div && (operand_a_i == INT_MIN) && (operand_b_i == MINUS_ONE);

  always_comb begin
    hit_o    = 1'b0;
    result_o = '0;
    if (div_zero) begin
      hit_o    = 1'b1;
      result_o = is_rem ? operand_a_i : MINUS_ONE;
    end else if (div_ovf) begin
      hit_o    = 1'b1;
      result_o = is_rem ? '0 : INT_MIN;
    end
  end

endmodule

// File: rtl/mdu_issue_ctrl.sv
// EX-stage requester for a multi-cycle MDU: registers one op, resolves divide
// corner cases locally, otherwise runs req/gnt/rvalid and holds the result for writeback.
module mdu_issue_ctrl
  import mdu_pkg::*;
#(
  parameter int WORD_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ex_valid_i,
  input  logic                 mdu_en_i,
  output logic                 ex_ready_o,
  input  logic [MDU_OP_W-1:0]  operator_i,
  input  logic [WORD_SIZE-1:0] operand_a_i,
  input  logic [WORD_SIZE-1:0] operand_b_i,
  input  logic [4:0]           rd_addr_i,
  input  logic                 flush_i,
  output logic                 mdu_req_o,
  input  logic                 mdu_gnt_i,
  output logic [MDU_OP_W-1:0]  mdu_operator_o,
  output logic [WORD_SIZE-1:0] mdu_operand_a_o,
  output logic [WORD_SIZE-1:0] mdu_operand_b_o,
  input  logic                 mdu_rvalid_i,
  input  logic [WORD_SIZE-1:0] mdu_result_i,
  output logic                 wb_valid_o,
  input  logic                 wb_ready_i,
  output logic [4:0]           wb_rd_addr_o,
  output logic [WORD_SIZE-1:0] wb_data_o,
  output logic                 busy_o
);

  mdu_state_e state_q, state_d;
  logic       kill_q, kill_d;

  logic [MDU_OP_W-1:0]         op_p0;
  logic signed [WORD_SIZE-1:0] opa_p0;
  logic signed [WORD_SIZE-1:0] opb_p0;
  logic [4:0]                  rd_p0;
  logic signed [WORD_SIZE-1:0] res_p1;

  logic                        accept;
  logic                        kill_eff;
  logic                        rsp_take;
  logic                        sc_hit;
  logic signed [WORD_SIZE-1:0] sc_result;

  mdu_special_case #(
    .WORD_SIZE (WORD_SIZE)
  ) u_special_case (
    .operator_i  (operator_i),
    .operand_a_i (operand_a_i),
    .operand_b_i (operand_b_i),
    .hit_o       (sc_hit),
    .result_o    (sc_result)
  );

  assign accept   = ex_valid_i & mdu_en_i & ex_ready_o & ~flush_i;
  // A flush in the same cycle as the response must already drop it.
  assign kill_eff = kill_q | flush_i;
  assign rsp_take = mdu_rvalid_i &
                    (((state_q == ST_REQ) & mdu_gnt_i) | (state_q == ST_WAIT));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
    end
  end

  always_comb begin
    state_d = state_q;
    kill_d  = kill_q;
    unique case (state_q)
      ST_IDLE: begin
        kill_d = 1'b0;
        if (accept) state_d = sc_hit ? ST_DONE : ST_REQ;
      end
      ST_REQ, ST_WAIT: begin
        kill_d = kill_eff;
        if ((state_q == ST_REQ) && mdu_gnt_i) state_d = ST_WAIT;
        if (rsp_take) begin
          state_d = kill_eff ? ST_IDLE : ST_DONE;
          kill_d  = 1'b0;
        end
      end
      ST_DONE: begin
        kill_d = 1'b0;
        if (wb_ready_i || flush_i) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        kill_d  = 1'b0;
      end
    endcase
  end

  always_comb begin
    ex_ready_o = 1'b0;
    mdu_req_o  = 1'b0;
    wb_valid_o = 1'b0;
    busy_o     = 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        ex_ready_o = 1'b1;
        busy_o     = 1'b0;
      end
      ST_REQ:  mdu_req_o  = 1'b1;
      ST_DONE: wb_valid_o = 1'b1;
      default: ;
    endcase
  end

  // Stage p0: operands captured on accept
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_p0  <= '0;
      opa_p0 <= '0;
      opb_p0 <= '0;
      rd_p0  <= '0;
    end else if (accept) begin
      op_p0  <= operator_i;
      opa_p0 <= operand_a_i;
      opb_p0 <= operand_b_i;
      rd_p0  <= rd_addr_i;
    end
  end

  // Stage p1: result from the local corner-case path or the MDU response
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_p1 <= '0;
    end else if (accept && sc_hit) begin
      res_p1 <= sc_result;
    end else if (rsp_take) begin
      res_p1 <= mdu_result_i;
    end
  end

  assign mdu_operator_o  = op_p0;
  assign mdu_operand_a_o = opa_p0;
  assign mdu_operand_b_o = opb_p0;
  assign wb_rd_addr_o    = rd_p0;
  assign wb_data_o       = res_p1;

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Bench for mdu_issue_ctrl: directed scenarios plus randomized ops against an
// M-extension arithmetic model; the bench itself plays the MDU.
module tb_mdu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid_i = 1'b0;
  logic        mdu_en_i = 1'b0;
  logic        ex_ready_o;
  logic [2:0]  operator_i = '0;
  logic [31:0] operand_a_i = '0;
  logic [31:0] operand_b_i = '0;
  logic [4:0]  rd_addr_i = '0;
  logic        flush_i = 1'b0;
  logic        mdu_req_o;
  logic        mdu_gnt_i = 1'b0;
  logic [2:0]  mdu_operator_o;
  logic [31:0] mdu_operand_a_o;
  logic [31:0] mdu_operand_b_o;
  logic        mdu_rvalid_i = 1'b0;
  logic [31:0] mdu_result_i = '0;
  logic        wb_valid_o;
  logic        wb_ready_i = 1'b0;
  logic [4:0]  wb_rd_addr_o;
  logic [31:0] wb_data_o;
  logic        busy_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mdu_issue_ctrl #(.WORD_SIZE(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ex_valid_i      (ex_valid_i),
    .mdu_en_i        (mdu_en_i),
    .ex_ready_o      (ex_ready_o),
    .operator_i      (operator_i),
    .operand_a_i     (operand_a_i),
    .operand_b_i     (operand_b_i),
    .rd_addr_i       (rd_addr_i),
    .flush_i         (flush_i),
    .mdu_req_o       (mdu_req_o),
    .mdu_gnt_i       (mdu_gnt_i),
    .mdu_operator_o  (mdu_operator_o),
    .mdu_operand_a_o (mdu_operand_a_o),
    .mdu_operand_b_o (mdu_operand_b_o),
    .mdu_rvalid_i    (mdu_rvalid_i),
    .mdu_result_i    (mdu_result_i),
    .wb_valid_o      (wb_valid_o),
    .wb_ready_i      (wb_ready_i),
    .wb_rd_addr_o    (wb_rd_addr_o),
    .wb_data_o       (wb_data_o),
    .busy_o          (busy_o)
  );

  // RISC-V M-extension semantics computed with plain 64-bit arithmetic
  function automatic logic [31:0] ref_m(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    int          qa, qb;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    qa = a;
    qb = b;
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return qa / qb;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return qa % qb;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return (op >= 3'd4 && b == 0) ||
           ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Full transaction; starts and ends just after a falling edge, leaves DUT idle
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int gnt_dly, input int rv_dly,
                        input int wbr_dly, input string tag);
    logic [31:0] exp;
    bit          spec;
    exp  = ref_m(op, a, b);
    spec = is_special(op, a, b);
    checks++;
    if (ex_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL %s ready_before_accept got=%b want=1", tag, ex_ready_o);
    end
    ex_valid_i = 1'b1; mdu_en_i = 1'b1;
    operator_i = op; operand_a_i = a; operand_b_i = b; rd_addr_i = rd;
    @(negedge clk);
    ex_valid_i = 1'b0; mdu_en_i = 1'($urandom);
    operator_i = 3'($urandom); operand_a_i = $urandom; operand_b_i = $urandom; rd_addr_i = 5'($urandom);
    if (!spec) begin
      for (int i = 0; i <= gnt_dly; i++) begin
        checks++;
        if ({mdu_req_o, ex_ready_o, wb_valid_o, busy_o} !== 4'b1001) begin
          failures++;
          $display("FAIL %s req_phase[%0d] req/rdy/wbv/busy got=%b want=1001", tag, i,
                   {mdu_req_o, ex_ready_o, wb_valid_o, busy_o});
        end
        checks++;
        if ({mdu_operator_o, mdu_operand_a_o, mdu_operand_b_o} !== {op, a, b}) begin
          failures++;
          $display("FAIL %s req_operands[%0d] got=%h/%h/%h want=%h/%h/%h", tag, i,
                   mdu_operator_o, mdu_operand_a_o, mdu_operand_b_o, op, a, b);
        end
        if (i == gnt_dly) begin
          mdu_gnt_i = 1'b1;
          if (rv_dly == 0) begin mdu_rvalid_i = 1'b1; mdu_result_i = exp; end
        end
        @(negedge clk);
        mdu_gnt_i = 1'b0; mdu_rvalid_i = 1'b0; mdu_result_i = $urandom;
      end
      for (int j = 1; j <= rv_dly; j++) begin
        checks++;
        if ({mdu_req_o, wb_valid_o, busy_o} !== 3'b001) begin
          failures++;
          $display("FAIL %s wait_phase[%0d] req/wbv/busy got=%b want=001", tag, j,
                   {mdu_req_o, wb_valid_o, busy_o});
        end
        if (j == rv_dly) begin mdu_rvalid_i = 1'b1; mdu_result_i = exp; end
        @(negedge clk);
        mdu_rvalid_i = 1'b0; mdu_result_i = $urandom;
      end
    end
    for (int k = 0; k <= wbr_dly; k++) begin
      checks++;
      if ({wb_valid_o, ex_ready_o, mdu_req_o, busy_o} !== 4'b1001) begin
        failures++;
        $display("FAIL %s done[%0d] wbv/rdy/req/busy got=%b want=1001", tag, k,
                 {wb_valid_o, ex_ready_o, mdu_req_o, busy_o});
      end
      checks++;
      if ({wb_data_o, wb_rd_addr_o} !== {exp, rd}) begin
        failures++;
        $display("FAIL %s wb_data_rd[%0d] got=%h/%0d want=%h/%0d", tag, k, wb_data_o, wb_rd_addr_o, exp, rd);
      end
      if (k == wbr_dly) wb_ready_i = 1'b1;
      @(negedge clk);
      wb_ready_i = 1'b0;
    end
    checks++;
    if ({ex_ready_o, wb_valid_o, busy_o} !== 3'b100) begin
      failures++;
      $display("FAIL %s back_to_idle rdy/wbv/busy got=%b want=100", tag, {ex_ready_o, wb_valid_o, busy_o});
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if ({ex_ready_o, mdu_req_o, wb_valid_o, busy_o} !== 4'b1000) begin
      failures++;
      $display("FAIL %s ctrl rdy/req/wbv/busy got=%b want=1000", tag, {ex_ready_o, mdu_req_o, wb_valid_o, busy_o});
    end
    checks++;
    if ({mdu_operator_o, mdu_operand_a_o, mdu_operand_b_o, wb_rd_addr_o, wb_data_o} !== '0) begin
      failures++;
      $display("FAIL %s data op/a/b/rd/wd got=%h/%h/%h/%h/%h want=0", tag, mdu_operator_o,
               mdu_operand_a_o, mdu_operand_b_o, wb_rd_addr_o, wb_data_o);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("after_reset");
  endtask

  task automatic test_mul();
    run_op(3'd0, 32'd3, 32'd5, 5'd11, 2, 4, 0, "mul_3x5");
  endtask

  task automatic test_special();
    run_op(3'd5, 32'd7, 32'd0, 5'd3, 0, 0, 0, "divu_by_zero");
    run_op(3'd6, 32'd7, 32'd0, 5'd4, 0, 0, 0, "rem_by_zero");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd5, 0, 0, 0, "div_overflow");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 0, 0, 0, "rem_overflow");
    run_op(3'd4, 32'h1234, 32'd0, 5'd7, 0, 0, 1, "div_by_zero");
    run_op(3'd7, 32'hDEAD_BEEF, 32'd0, 5'd8, 0, 0, 0, "remu_by_zero");
  endtask

  task automatic test_flush_wait();
    ex_valid_i = 1'b1; mdu_en_i = 1'b1; operator_i = 3'd4;
    operand_a_i = 32'd100; operand_b_i = 32'd7; rd_addr_i = 5'd9;
    @(negedge clk);
    ex_valid_i = 1'b0; mdu_en_i = 1'b0;
    mdu_gnt_i = 1'b1;
    @(negedge clk);
    mdu_gnt_i = 1'b0;
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    for (int j = 1; j <= 3; j++) begin
      checks++;
      if ({wb_valid_o, ex_ready_o, busy_o} !== 3'b001) begin
        failures++;
        $display("FAIL flush_wait drain[%0d] wbv/rdy/busy got=%b want=001", j, {wb_valid_o, ex_ready_o, busy_o});
      end
      if (j == 3) begin mdu_rvalid_i = 1'b1; mdu_result_i = 32'd14; end
      @(negedge clk);
      mdu_rvalid_i = 1'b0;
    end
    checks++;
    if ({ex_ready_o, wb_valid_o, busy_o} !== 3'b100) begin
      failures++;
      $display("FAIL flush_wait after_rvalid rdy/wbv/busy got=%b want=100", {ex_ready_o, wb_valid_o, busy_o});
    end
    run_op(3'd0, 32'd6, 32'd7, 5'd10, 0, 1, 0, "after_flush_wait");
  endtask

  task automatic test_flush_req();
    ex_valid_i = 1'b1; mdu_en_i = 1'b1; operator_i = 3'd1;
    operand_a_i = 32'hFFFF_0000; operand_b_i = 32'd9; rd_addr_i = 5'd12;
    @(negedge clk);
    ex_valid_i = 1'b0; mdu_en_i = 1'b0;
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    checks++;
    if ({mdu_req_o, mdu_operand_a_o} !== {1'b1, 32'hFFFF_0000}) begin
      failures++;
      $display("FAIL flush_req held req/a got=%b/%h want=1/ffff0000", mdu_req_o, mdu_operand_a_o);
    end
    mdu_gnt_i = 1'b1; mdu_rvalid_i = 1'b1; mdu_result_i = 32'h5555_5555;
    @(negedge clk);
    mdu_gnt_i = 1'b0; mdu_rvalid_i = 1'b0;
    checks++;
    if ({ex_ready_o, wb_valid_o, busy_o} !== 3'b100) begin
      failures++;
      $display("FAIL flush_req drained rdy/wbv/busy got=%b want=100", {ex_ready_o, wb_valid_o, busy_o});
    end
  endtask

  task automatic test_flush_done();
    ex_valid_i = 1'b1; mdu_en_i = 1'b1; operator_i = 3'd5;
    operand_a_i = 32'd5; operand_b_i = 32'd0; rd_addr_i = 5'd13;
    @(negedge clk);
    ex_valid_i = 1'b0; mdu_en_i = 1'b0;
    checks++;
    if (wb_valid_o !== 1'b1) begin
      failures++;
      $display("FAIL flush_done in_done wbv got=%b want=1", wb_valid_o);
    end
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    checks++;
    if ({ex_ready_o, wb_valid_o} !== 2'b10) begin
      failures++;
      $display("FAIL flush_done idle rdy/wbv got=%b want=10", {ex_ready_o, wb_valid_o});
    end
  endtask

  task automatic test_idle_ignore();
    ex_valid_i = 1'b1; mdu_en_i = 1'b1; flush_i = 1'b1; operator_i = 3'd0;
    @(negedge clk);
    flush_i = 1'b0; mdu_en_i = 1'b0;
    @(negedge clk);
    ex_valid_i = 1'b0;
    mdu_rvalid_i = 1'b1; mdu_result_i = 32'hCAFE_F00D;
    @(negedge clk);
    mdu_rvalid_i = 1'b0;
    checks++;
    if ({ex_ready_o, mdu_req_o, wb_valid_o, busy_o} !== 4'b1000) begin
      failures++;
      $display("FAIL idle_ignore rdy/req/wbv/busy got=%b want=1000", {ex_ready_o, mdu_req_o, wb_valid_o, busy_o});
    end
  endtask

  task automatic test_back_to_back();
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd14, 1, 2, 3, "b2b_mulhu");
    run_op(3'd2, 32'hFFFF_FFFE, 32'd3, 5'd15, 0, 0, 0, "b2b_mulhsu");
    run_op(3'd7, 32'd100, 32'd7, 5'd16, 0, 1, 0, "b2b_remu");
  endtask

  task automatic test_reset_mid();
    ex_valid_i = 1'b1; mdu_en_i = 1'b1; operator_i = 3'd0;
    operand_a_i = 32'd9; operand_b_i = 32'd9; rd_addr_i = 5'd17;
    @(negedge clk);
    ex_valid_i = 1'b0; mdu_en_i = 1'b0;
    mdu_gnt_i = 1'b1;
    @(negedge clk);
    mdu_gnt_i = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset_mid");
    rst_n = 1'b1;
    @(negedge clk);
    run_op(3'd0, 32'd9, 32'd9, 5'd18, 0, 0, 0, "after_reset_mid");
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a, b;
    for (int n = 0; n < 40; n++) begin
      op = 3'($urandom);
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 5) == 0) b = 32'd0;
      if ($urandom_range(0, 7) == 0) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 15));
      run_op(op, a, b, 5'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 2)), $sformatf("rand%0d", n));
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_mul();
    test_special();
    test_flush_wait();
    test_flush_req();
    test_flush_done();
    test_idle_ignore();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
